// File: rtl/mem_copy_dma.sv
// Byte-at-a-time memory copy initiator: reads SRC, writes DST, LEN times,
// and accumulates an 8-bit checksum of the bytes written.
module mem_copy_dma #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [AW-1:0] len,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] checksum,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd_en,
   output logic          mem_wr_en,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

   state_t        state, state_d;
   logic [AW-1:0] src, src_d, dst, dst_d, count, count_d;
   logic [DW-1:0] data_buf, data_buf_d, checksum_d;
   logic          busy_d, done_d, rd_d, wr_d;
   logic [AW-1:0] addr_d;
   logic [DW-1:0] wdata_d;

   // Outputs are registered, so their next values are computed from the
   // state being entered rather than the state being left.
   always_comb begin
      state_d    = state;
      src_d      = src;
      dst_d      = dst;
      count_d    = count;
      data_buf_d = data_buf;
      checksum_d = checksum;
      busy_d     = busy;
      done_d     = 1'b0;
      addr_d     = mem_addr;
      rd_d       = 1'b0;
      wr_d       = 1'b0;
      wdata_d    = mem_wdata;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               src_d      = src_addr;
               dst_d      = dst_addr;
               count_d    = len;
               checksum_d = '0;
               if (len != '0) begin
                  state_d = S_READ;
                  busy_d  = 1'b1;
                  addr_d  = src_addr;
                  rd_d    = 1'b1;
               end else begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end
            end
         end
         S_READ: begin
            data_buf_d = mem_rdata;
            state_d    = S_WRITE;
            addr_d     = dst;
            wdata_d    = mem_rdata;
            wr_d       = 1'b1;
         end
         S_WRITE: begin
            checksum_d = checksum + data_buf;
            src_d      = src + 1'b1;
            dst_d      = dst + 1'b1;
            count_d    = count - 1'b1;
            if (count == AW'(1)) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d = S_READ;
               addr_d  = src + 1'b1;
               rd_d    = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         src       <= '0;
         dst       <= '0;
         count     <= '0;
         data_buf  <= '0;
         checksum  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_addr  <= '0;
         mem_rd_en <= 1'b0;
         mem_wr_en <= 1'b0;
         mem_wdata <= '0;
      end else begin
         state     <= state_d;
         src       <= src_d;
         dst       <= dst_d;
         count     <= count_d;
         data_buf  <= data_buf_d;
         checksum  <= checksum_d;
         busy      <= busy_d;
         done      <= done_d;
         mem_addr  <= addr_d;
         mem_rd_en <= rd_d;
         mem_wr_en <= wr_d;
         mem_wdata <= wdata_d;
      end
   end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: 256x8 memory model, write scoreboard fed by a
// reference copy model, latency/checksum/reset checks.
module tb_mem_copy_dma;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] src_addr, dst_addr, len;
   logic       busy, done;
   logic [7:0] checksum, mem_addr, mem_wdata, mem_rdata;
   logic       mem_rd_en, mem_wr_en;

   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   logic       pl_en = 1'b0;
   logic [7:0] pl_addr = '0, pl_data = '0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;
   wr_t sb[$];

   int n_vec = 0;
   int n_err = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   mem_copy_dma #(.AW(8), .DW(8)) dut (
      .clk(clk), .reset(reset), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
      .busy(busy), .done(done), .checksum(checksum),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
   end
   assign mem_rdata = mem[mem_addr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Write scoreboard and done-pulse counter.
   always @(negedge clk) begin
      if (!reset) begin
         if (mem_rd_en || mem_wr_en) chk("rd_wr_excl", 32'(mem_rd_en & mem_wr_en), 0);
         if (mem_wr_en) begin
            if (sb.size() == 0) chk("unexpected_write", 1, 0);
            else begin
               wr_t e;
               e = sb.pop_front();
               chk("wr_addr", mem_addr, e.a);
               chk("wr_data", mem_wdata, e.d);
            end
         end
         if (done) done_cnt++;
      end
   end

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
      for (int i = 0; i < int'(l); i++) begin
         logic [7:0] v;
         v = ref_mem[8'(s + i)];
         ref_mem[8'(d + i)] = v;
         sb.push_back('{8'(d + i), v});
      end
   endtask

   task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                           input logic [7:0] exp_sum, input bit poke);
      int cyc;
      int dc0;
      model_copy(s, d, l);
      dc0 = done_cnt;
      @(negedge clk);
      src_addr = s; dst_addr = d; len = l; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      src_addr = 8'($urandom); dst_addr = 8'($urandom); len = 8'($urandom_range(1, 255));
      chk("busy_after_start", busy, 32'(l != 0));
      cyc = 1;
      while (!done && cyc < 600) begin
         start = (poke && cyc == 3);
         @(posedge clk); #1;
         cyc++;
      end
      start = poke;
      chk("done_latency", cyc, 2 * int'(l) + 1);
      chk("done_high", done, 1);
      chk("checksum", checksum, exp_sum);
      chk("busy_in_done", busy, 0);
      @(posedge clk); #1;
      start = 1'b0;
      chk("done_pulse_width", done, 0);
      chk("checksum_hold", checksum, exp_sum);
      repeat (3) @(posedge clk);
      #1;
      chk("done_count", done_cnt - dc0, 1);
      chk("sb_drained", sb.size(), 0);
      chk("busy_idle", busy, 0);
      for (int i = 0; i < int'(l); i++)
         chk("mem_dst", mem[8'(d + i)], ref_mem[8'(d + i)]);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      for (int i = 0; i < 256; i++) preload(8'(i), 8'h00);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_checksum", checksum, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_wr_en", mem_wr_en, 0);
      chk("rst_wdata", mem_wdata, 0);
      @(negedge clk); reset = 1'b0;

      // basic copy
      preload(8'h10, 8'h01); preload(8'h11, 8'h02);
      preload(8'h12, 8'h03); preload(8'h13, 8'h04);
      run_copy(8'h10, 8'h80, 8'd4, 8'h0A, 1'b0);
      // zero length clears checksum, no writes
      run_copy(8'h10, 8'h90, 8'd0, 8'h00, 1'b0);
      // source wraps through 0xFF
      preload(8'hFE, 8'hAA); preload(8'hFF, 8'hBB); preload(8'h00, 8'hCC);
      run_copy(8'hFE, 8'h40, 8'd3, 8'h31, 1'b0);
      // overlapping forward copy replicates first byte
      preload(8'h20, 8'h11); preload(8'h21, 8'h22);
      preload(8'h22, 8'h33); preload(8'h23, 8'h44);
      run_copy(8'h20, 8'h21, 8'd3, 8'h33, 1'b0);
      for (int i = 0; i < 4; i++) chk("overlap_mem", mem[8'(8'h20 + i)], 8'h11);

      // reset during second WRITE
      preload(8'h50, 8'h5A); preload(8'h51, 8'h5B);
      preload(8'h52, 8'h5C); preload(8'h53, 8'h5D);
      sb.push_back('{8'h90, 8'h5A});
      ref_mem[8'h90] = 8'h5A;
      @(negedge clk);
      src_addr = 8'h50; dst_addr = 8'h90; len = 8'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("second_write_en", mem_wr_en, 1);
      chk("second_write_addr", mem_addr, 8'h91);
      reset = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_checksum", checksum, 0);
      chk("abort_addr", mem_addr, 0);
      chk("abort_rd_en", mem_rd_en, 0);
      chk("abort_wr_en", mem_wr_en, 0);
      chk("abort_wdata", mem_wdata, 0);
      @(posedge clk); #1;
      chk("abort_hold_wr_en", mem_wr_en, 0);
      @(negedge clk); reset = 1'b0;
      chk("abort_first_byte", mem[8'h90], 8'h5A);
      chk("abort_second_byte", mem[8'h91], 8'h00);
      chk("abort_sb", sb.size(), 0);

      // fresh copy after reset
      run_copy(8'h10, 8'hA0, 8'd2, 8'h03, 1'b0);
      // start pulses while busy and in DONE are ignored
      run_copy(8'h10, 8'hC0, 8'd3, 8'h06, 1'b1);
      chk("poke_untouched", mem[8'hC3], ref_mem[8'hC3]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
